// File: rtl/toy_pkg.sv
// -----------------------------------------------------------------------------
// toy_pkg
// Shared definitions for the RISC_TOY pipeline slice.
//   - default word-address / instruction widths
//   - opcode constants
//   - NOP encoding
//   - fetch-entry record {pc, instr}
// No ports (package).
// -----------------------------------------------------------------------------
package toy_pkg;

    localparam int TOY_AW = 30;
    localparam int TOY_DW = 32;

    // All-zero instruction word is the architectural NOP.
    localparam logic [TOY_DW-1:0] TOY_NOP = 32'h0000_0000;

    typedef enum logic [4:0] {
        OP_ADDI = 5'd0,
        OP_ANDI = 5'd1,
        OP_ORI  = 5'd2,
        OP_MOVI = 5'd3,
        OP_ADD  = 5'd4,
        OP_SUB  = 5'd5,
        OP_NEG  = 5'd6,
        OP_NOT  = 5'd7,
        OP_AND  = 5'd8,
        OP_OR   = 5'd9,
        OP_XOR  = 5'd10,
        OP_LSR  = 5'd11,
        OP_ASR  = 5'd12,
        OP_SHL  = 5'd13,
        OP_ROR  = 5'd14,
        OP_BR   = 5'd15,
        OP_BRL  = 5'd16,
        OP_J    = 5'd17,
        OP_JL   = 5'd18,
        OP_LD   = 5'd19,
        OP_LDR  = 5'd20,
        OP_ST   = 5'd21,
        OP_STR  = 5'd22
    } toy_opcode_e;

    // One prefetch-queue record: the word address and the word fetched there.
    typedef struct packed {
        logic [TOY_AW-1:0] pc;
        logic [TOY_DW-1:0] instr;
    } fetch_entry_t;

    // Builds a fetch entry from its two fields.
    function automatic fetch_entry_t make_entry(input logic [TOY_AW-1:0] pc,
                                                input logic [TOY_DW-1:0] instr);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        return e;
    endfunction

    // Even parity over an instruction word, for downstream integrity checks.
    function automatic logic instr_parity(input logic [TOY_DW-1:0] instr);
        return ^instr;
    endfunction

endpackage

// File: rtl/toy_sync_fifo.sv
// -----------------------------------------------------------------------------
// toy_sync_fifo
// Synchronous FIFO with a registered head word and a synchronous clear.
// Ports:
//   CLK      in   clock, rising edge
//   RSTN     in   asynchronous active-low reset
//   i_clear  in   synchronous clear (drops all entries, pointers to zero)
//   i_push   in   write i_wdata at the edge (ignored when full without pop)
//   i_wdata  in   WIDTH data to write
//   i_pop    in   remove the head at the edge (ignored when empty)
//   o_head   out  WIDTH head entry, straight from a register
//   o_count  out  occupancy, $clog2(DEPTH+1) bits
// DEPTH must be a power of two, >= 2, so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module toy_sync_fifo
    import toy_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = TOY_AW + TOY_DW
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_pop_ok;
    logic             w_push_ok;
    logic [WIDTH-1:0] w_head_nxt;

    assign w_pop_ok  = i_pop & (r_count != CNT_ZERO);
    // A full FIFO can still take a push when the head leaves in the same edge.
    assign w_push_ok = i_push & ((r_count != CNT_FULL) | w_pop_ok);

    // Next head word: keeping it in a register cuts any write-data to head path.
    always_comb begin
        w_head_nxt = r_head;
        if (i_clear) begin
            w_head_nxt = {WIDTH{1'b0}};
        end else if (w_pop_ok && (r_count > CNT_ONE)) begin
            // Second-oldest entry is already stored; it becomes the head.
            w_head_nxt = r_mem[r_rd_ptr + PTR_ONE];
        end else if (w_push_ok && ((r_count == CNT_ZERO) || w_pop_ok)) begin
            // Empty, or the only entry leaves: the incoming word is the new head.
            w_head_nxt = i_wdata;
        end else begin
            w_head_nxt = r_head;
        end
    end

    // Storage array write port.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_push_ok && !i_clear) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= CNT_ZERO;
            r_head   <= {WIDTH{1'b0}};
        end else if (i_clear) begin
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= CNT_ZERO;
            r_head   <= w_head_nxt;
        end else begin
            r_head <= w_head_nxt;
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/toy_fetch_unit.sv
// -----------------------------------------------------------------------------
// toy_fetch_unit
// Instruction-fetch front end: program counter, request engine toward a
// one-cycle-latency instruction memory, and a DEPTH-entry prefetch queue
// toward decode.
// Ports:
//   CLK          in   clock, rising edge
//   RSTN         in   asynchronous active-low reset
//   IREQ         out  memory request this cycle
//   IADDR        out  AW word address of the request (the PC)
//   INSTR        in   DW read data, valid the cycle after IREQ
//   REDIR_VALID  in   EX redirect strobe
//   REDIR_ADDR   in   AW redirect target (word address)
//   FV           out  head-of-queue valid
//   FINSTR       out  DW head instruction (registered)
//   FPC          out  AW head word address (registered)
//   FREADY       in   decode accepts the head when FV
//   LEVEL        out  queue occupancy
// -----------------------------------------------------------------------------
module toy_fetch_unit
    import toy_pkg::*;
#(
    parameter int            AW       = TOY_AW,
    parameter int            DW       = TOY_DW,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    output logic                       IREQ,
    output logic [AW-1:0]              IADDR,
    input  logic [DW-1:0]              INSTR,
    input  logic                       REDIR_VALID,
    input  logic [AW-1:0]              REDIR_ADDR,
    output logic                       FV,
    output logic [DW-1:0]              FINSTR,
    output logic [AW-1:0]              FPC,
    input  logic                       FREADY,
    output logic [$clog2(DEPTH+1)-1:0] LEVEL
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0]   OCC_LIMIT = (CW+1)'(DEPTH);
    localparam logic [AW-1:0] PC_ONE    = AW'(1);

    logic          r_started;
    logic          r_inflight;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_pend_addr;

    logic [CW-1:0]    w_count;
    logic [CW:0]      w_occ;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic [AW+DW-1:0] w_head;

    // Occupancy includes the slot reserved by an outstanding request, so a
    // response can always be pushed without overflowing.
    assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue = r_started & ~REDIR_VALID & (w_occ < OCC_LIMIT);
    assign w_push  = r_inflight & ~REDIR_VALID;
    assign w_pop   = FV & FREADY;

    // Request engine: start-up, PC advance, outstanding-request tracking.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_started   <= 1'b0;
            r_inflight  <= 1'b0;
            r_pc        <= RESET_PC;
            r_pend_addr <= {AW{1'b0}};
        end else begin
            r_started <= 1'b1;
            if (REDIR_VALID) begin
                // Last redirect wins; any outstanding response is abandoned.
                r_pc       <= REDIR_ADDR;
                r_inflight <= 1'b0;
            end else if (w_issue) begin
                r_pend_addr <= r_pc;
                r_pc        <= r_pc + PC_ONE;
                r_inflight  <= 1'b1;
            end else begin
                r_inflight <= 1'b0;
            end
        end
    end

    toy_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (AW + DW)
    ) u_queue (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .i_clear (REDIR_VALID),
        .i_push  (w_push),
        .i_wdata ({r_pend_addr, INSTR}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign IREQ   = w_issue;
    assign IADDR  = r_pc;
    assign FV     = (w_count != {CW{1'b0}});
    assign FPC    = w_head[AW+DW-1:DW];
    assign FINSTR = w_head[DW-1:0];
    assign LEVEL  = w_count;

endmodule

// File: tb/tb_toy_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_toy_fetch_unit
// Randomized bench for toy_fetch_unit against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_toy_fetch_unit;

    localparam int            AW       = 30;
    localparam int            DW       = 32;
    localparam int            DEPTH    = 4;
    localparam logic [AW-1:0] RESET_PC = 30'h0;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          IREQ;
    logic [AW-1:0] IADDR;
    logic [DW-1:0] INSTR;
    logic          REDIR_VALID;
    logic [AW-1:0] REDIR_ADDR;
    logic          FV;
    logic [DW-1:0] FINSTR;
    logic [AW-1:0] FPC;
    logic          FREADY;
    logic [2:0]    LEVEL;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
    } ent_t;

    ent_t          m_q[$];     // instructions waiting for decode
    logic [AW-1:0] m_fly[$];   // addresses requested, response not yet seen
    logic [AW-1:0] m_pc;
    bit            m_started;
    bit            m_ireq;

    toy_fetch_unit #(
        .AW (AW), .DW (DW), .DEPTH (DEPTH), .RESET_PC (RESET_PC)
    ) dut (
        .CLK (CLK), .RSTN (RSTN), .IREQ (IREQ), .IADDR (IADDR),
        .INSTR (INSTR), .REDIR_VALID (REDIR_VALID), .REDIR_ADDR (REDIR_ADDR),
        .FV (FV), .FINSTR (FINSTR), .FPC (FPC), .FREADY (FREADY),
        .LEVEL (LEVEL)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'h1000_0000 + {2'b00, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fly.delete();
        m_pc      = RESET_PC;
        m_started = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ireq"},   IREQ,   64'd0);
        check({tag, "_iaddr"},  IADDR,  RESET_PC);
        check({tag, "_fv"},     FV,     64'd0);
        check({tag, "_finstr"}, FINSTR, 64'd0);
        check({tag, "_fpc"},    FPC,    64'd0);
        check({tag, "_level"},  LEVEL,  64'd0);
    endtask

    // Expected outputs for the current cycle, given the inputs now driven.
    task automatic check_outputs();
        m_ireq = m_started && !REDIR_VALID && ((m_q.size() + m_fly.size()) < DEPTH);
        check("ireq",  IREQ,  m_ireq);
        check("iaddr", IADDR, m_pc);
        check("fv",    FV,    m_q.size() != 0);
        check("level", LEVEL, m_q.size());
        if (m_q.size() != 0) begin
            check("fpc",    FPC,    m_q[0].pc);
            check("finstr", FINSTR, m_q[0].instr);
        end
    endtask

    // State change at a rising edge with RSTN high.
    task automatic model_edge();
        logic [AW-1:0] old[$];
        ent_t          e;
        if (m_q.size() != 0 && FREADY) void'(m_q.pop_front());
        old = m_fly;
        m_fly.delete();
        if (REDIR_VALID) begin
            m_q.delete();
            m_pc = REDIR_ADDR;
        end else begin
            if (old.size() != 0) begin
                e.pc    = old[0];
                e.instr = INSTR;
                m_q.push_back(e);
            end
            if (m_ireq) begin
                m_fly.push_back(m_pc);
                m_pc = m_pc + 30'd1;
            end
        end
        m_started = 1'b1;
    endtask

    // One clock: drive inputs, check outputs, advance across the edge.
    task automatic cycle(input bit rv, input logic [AW-1:0] ra, input bit rdy);
        REDIR_VALID = rv;
        REDIR_ADDR  = ra;
        FREADY      = rdy;
        INSTR       = (m_fly.size() != 0) ? mem_word(m_fly[0]) : DW'($urandom);
        #1;
        check_outputs();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic run(input int n, input int rdy_pct, input int rv_pct,
                       input logic [AW-1:0] base);
        bit            rv;
        bit            rdy;
        logic [AW-1:0] ra;
        for (int i = 0; i < n; i++) begin
            rv  = ($urandom_range(99) < rv_pct);
            rdy = ($urandom_range(99) < rdy_pct);
            ra  = base + AW'($urandom_range(15));
            cycle(rv, ra, rdy);
        end
    endtask

    initial begin
        RSTN        = 1'b0;
        REDIR_VALID = 1'b0;
        REDIR_ADDR  = 30'h0;
        FREADY      = 1'b0;
        INSTR       = 32'h0;
        model_reset();
        #1;
        check_reset_values("rst");
        repeat (2) @(posedge CLK);
        #1;
        RSTN = 1'b1;

        // Streaming with decode always ready.
        run(20, 100, 0, 30'h0);
        // Decode stalled: queue fills, requests stop.
        run(12, 0, 0, 30'h0);
        // Single pop, then stalled again: one more request.
        cycle(1'b0, 30'h0, 1'b1);
        run(6, 0, 0, 30'h0);
        // Drain partially, then redirect with a request outstanding.
        run(2, 100, 0, 30'h0);
        cycle(1'b1, 30'h40, 1'b0);
        run(8, 100, 0, 30'h0);
        // Back-to-back redirects: only the last target is fetched.
        cycle(1'b1, 30'h10, 1'b1);
        cycle(1'b1, 30'h20, 1'b1);
        run(10, 100, 0, 30'h0);
        // PC wrap at the top of the address space.
        cycle(1'b1, 30'h3FFF_FFFE, 1'b1);
        run(10, 100, 0, 30'h0);

        // Randomized mixes of stalls and redirects.
        run(300, 70, 5, 30'h0);
        run(300, 30, 10, 30'h3FFF_FFF8);
        run(200, 90, 2, 30'h100);

        // Reset in the middle of activity.
        cycle(1'b1, 30'h100, 1'b1);
        run(3, 0, 0, 30'h0);
        RSTN = 1'b0;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(posedge CLK);
        #1;
        check_reset_values("midrst_hold");
        RSTN = 1'b1;
        run(20, 100, 0, 30'h0);
        run(100, 50, 5, 30'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/toy_fetch_unit.md
# toy_fetch_unit

Parametrised instruction-fetch front end for the RISC_TOY pipeline. It replaces the single-register IF stage with a program counter, a request engine to a one-cycle-latency instruction memory, and a DEPTH-entry prefetch queue toward decode. Decode stalls through a valid/ready handshake. EX redirects (branch/jump targets) flush the queue and squash any in-flight fetch. The unit sits between the instruction-memory port of RISC_TOY and the ID stage.

## Interface
Parameters:
- AW, 30, word-address width of IADDR and the PC
- DW, 32, instruction width
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- RESET_PC, 0, word address fetched first after reset

Ports:
- CLK  in  1  clock, rising edge
- RSTN  in  1  reset, asynchronous, active-low
- IREQ  out  1  instruction-memory request this cycle
- IADDR  out  AW  word address of the request
- INSTR  in  DW  memory read data; valid the cycle after IREQ=1
- REDIR_VALID  in  1  EX redirect strobe, single cycle
- REDIR_ADDR  in  AW  redirect target, word address (byte target >> 2)
- FV  out  1  head-of-queue instruction valid
- FINSTR  out  DW  head-of-queue instruction
- FPC  out  AW  word address of FINSTR
- FREADY  in  1  decode accepts the head entry when FV=1
- LEVEL  out  $clog2(DEPTH+1)  current queue occupancy

## Operation
- State:
  - PC (AW)
  - started flag
  - inflight flag
  - queue of {PC, INSTR} pairs with read/write pointers and a count
- started is cleared in reset and set on the first clock edge after RSTN deasserts. IREQ=0 while started=0.
- Issue rule: IREQ = started & !REDIR_VALID & (count + inflight < DEPTH). IADDR = PC.
- On an issue, the edge latches the pending address as PC, sets PC <= PC+1 (mod 2^AW, wraps silently) and sets inflight <= 1. With no issue, inflight <= 0.
- Response: in the cycle after an issue (inflight=1) and without REDIR_VALID, {pending address, INSTR} is pushed at the closing edge. Reserving the slot at issue guarantees the push never overflows.
- Pop: when FV & FREADY, the head is removed at the edge.
- A push and a pop in the same cycle leave count unchanged.
- FV = (count != 0). FINSTR/FPC are the head entry, driven from registers (no INSTR→FINSTR combinational path).
- Redirect (REDIR_VALID=1):
  - The queue is cleared (count <= 0, pointers <= 0).
  - A response arriving this cycle is dropped.
  - No request is issued this cycle.
  - PC <= REDIR_ADDR, inflight <= 0.
  - A simultaneous FV & FREADY handshake still completes; decode is responsible for squashing that younger instruction.
- A redirect in consecutive cycles is legal; the last one wins.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); in-flight responses are ignored.

## Timing
- Reset values:
  - IREQ=0, IADDR=RESET_PC
  - FV=0, FINSTR=0, FPC=0
  - LEVEL=0
  - PC=RESET_PC, inflight=0, started=0
- First IREQ: second cycle after RSTN rises. The first edge sets started; IREQ=1 from then on.
- Fetch latency: IREQ in cycle t → INSTR sampled in cycle t+1 → FV=1 in cycle t+2.
- Steady state with FREADY=1: one instruction per cycle.
- Redirect penalty: REDIR_VALID in cycle r → IREQ with IADDR=REDIR_ADDR in r+1 → first FV of the target in r+3.
- Full queue: IREQ stays 0 until a pop. The request issues in the cycle after the popping edge.

## Structure
- Shared package toy_pkg holds:
  - opcode constants (ADDI…STR)
  - default AW/DW
  - NOP encoding (all zeros)
  - a fetch-entry struct {pc, instr}
- One sub-module, toy_sync_fifo: parametrised DEPTH and WIDTH, synchronous clear input, push/pop, count output, registered head. The request/redirect logic stays in toy_fetch_unit.

## Test plan
- Reset, DEPTH=4, RESET_PC=0, FREADY=1, memory returns 0x1000_0000+addr → IADDR 0,1,2,… on consecutive cycles. FV first high 2 cycles after the first IREQ. FPC sequence 0,1,2,… with matching FINSTR.
- FREADY=0 from reset → exactly 4 requests (IADDR 0–3), then IREQ=0. LEVEL=4. Raising FREADY for 1 cycle pops FPC=0; the next IREQ has IADDR=4.
- Redirect to 0x40 while LEVEL=3 with one request in flight → same cycle IREQ=0. Next cycle LEVEL=0 and IREQ with IADDR=0x40. The in-flight response never appears at FPC. Next FV has FPC=0x40.
- Redirects to 0x10 then 0x20 on back-to-back cycles → only 0x20 is fetched. No FPC of 0x10 is ever presented.
- PC=2^AW−1 with FREADY=1 → IADDR wraps to 0 on the next request. FPC sequence …,0x3FFF_FFFF,0.
- Assert RSTN low while LEVEL=2 and inflight=1 → all outputs at reset values in the same cycle. Restart fetches from RESET_PC.
